mux_nway_pipelined: RTL and testbench

Parametrised N-channel, WIDTH-bit registered multiplexer with a valid/ready handshake. It generalises the single-bit combinational mux to a one-stage pipelined channel selector with two modes: explicit select or automatic round-robin scan. Optional output inversion is available at compile time. It sits between multi-channel producers and a single downstream consumer in the combinational/sequential exercise set.

---
 rtl/mux_nway_pipelined.sv | 81 ++++++++
 tb/tb_mux_nway_pipelined.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_nway_pipelined.sv
// mux_nway_pipelined: N_CH-channel, WIDTH-bit one-stage registered mux with
// a valid/ready handshake. The channel comes either from in_sel (explicit
// mode) or from an internal round-robin pointer (auto mode).
// Compile-time option: MUX_INVERT_EN adds the inv port, which XORs the
// selected data with {WIDTH{inv}} before it is registered.
module mux_nway_pipelined #(
  parameter  int WIDTH = 8,
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  auto_en,
`ifdef MUX_INVERT_EN
  input  logic                  inv,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch
);

  logic [SEL_W-1:0]            rr_ptr;
  logic [SEL_W-1:0]            rr_nxt;
  logic [SEL_W-1:0]            ch;
  logic                        acc;
  logic [N_CH-1:0][WIDTH-1:0]  lane;
  logic [WIDTH-1:0]            sel_data;
  logic [WIDTH-1:0]            load_data;

  // Ready depends only on the output register state, so a producer may
  // legally wait for ready before raising valid.
  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign ch       = auto_en ? rr_ptr : in_sel;
  assign rr_nxt   = (rr_ptr == SEL_W'(N_CH - 1)) ? '0 : rr_ptr + 1'b1;

  // Each lane passes its data only when it is the chosen channel; an
  // out-of-range select matches no lane, so the OR below yields all-zero.
  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    assign lane[k] = (ch == SEL_W'(k)) ? in_data[k*WIDTH +: WIDTH] : '0;
  end

  // OR-reduce the one-hot-masked lanes into the selected word.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_CH; k++) sel_data = sel_data | lane[k];
  end

`ifdef MUX_INVERT_EN
  assign load_data = sel_data ^ {WIDTH{inv}};
`else
  assign load_data = sel_data;
`endif

  // Output register: load on accept, drop valid when drained with no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_ch    <= ch;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer: steps only on auto-mode accepts, wraps at N_CH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rr_ptr <= '0;
    else if (acc && auto_en) rr_ptr <= rr_nxt;
  end

endmodule

// File: tb/tb_mux_nway_pipelined.sv
// Directed bench for mux_nway_pipelined with WIDTH=8, N_CH=3.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mux_nway_pipelined;
  localparam int WIDTH = 8;
  localparam int N_CH  = 3;
  localparam int SEL_W = 2;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]      in_sel;
  logic                  auto_en;
`ifdef MUX_INVERT_EN
  logic                  inv;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;

  int n_cmp;
  int n_err;

  mux_nway_pipelined #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .auto_en   (auto_en),
`ifdef MUX_INVERT_EN
    .inv       (inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    in_data = {d2, d1, d0};
  endtask

  // Expected round-robin sequence for the auto-mode section.
  logic [1:0] rr_ch  [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
  logic [7:0] rr_dat [5] = '{8'h0A, 8'h0B, 8'h0C, 8'h0A, 8'h0B};

  initial begin
    n_cmp = 0;
    n_err = 0;
    // Reset held with random inputs.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    auto_en   = 1'b0;
    in_sel    = 2'd1;
`ifdef MUX_INVERT_EN
    inv       = 1'b1;
`endif
    in_data   = 24'($urandom);
    repeat (3) begin
      tick();
      in_data = 24'($urandom);
      in_sel  = 2'($urandom_range(0, 2));
    end
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'h00);
    chk("rst_out_ch",    32'(out_ch),    32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // First beat after reset.
    rst_n     = 1'b1;
`ifdef MUX_INVERT_EN
    inv       = 1'b0;
`endif
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_sel    = 2'd2;
    set_data(8'h01, 8'h02, 8'hA5);
    tick();
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_data",  32'(out_data),  32'hA5);
    chk("first_ch",    32'(out_ch),    32'd2);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_hold",  32'(out_data),  32'hA5);

    // Backpressure from channel 1.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    set_data(8'h00, 8'h11, 8'h00);
    tick();
    chk("bp_data0",  32'(out_data), 32'h11);
    chk("bp_ready0", 32'(in_ready), 32'd0);
    set_data(8'h00, 8'h22, 8'h00);
    repeat (2) begin
      tick();
      chk("bp_hold_data",  32'(out_data),  32'h11);
      chk("bp_hold_ch",    32'(out_ch),    32'd1);
      chk("bp_hold_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_beat2", 32'(out_data), 32'h22);
    set_data(8'h00, 8'h33, 8'h00);
    tick();
    chk("bp_beat3", 32'(out_data), 32'h33);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Round-robin wrap.
    set_data(8'h0A, 8'h0B, 8'h0C);
    auto_en  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_ch",    32'(out_ch),    32'(rr_ch[i]));
      chk("rr_data",  32'(out_data),  32'(rr_dat[i]));
      chk("rr_valid", 32'(out_valid), 32'd1);
    end
    auto_en = 1'b0;
    in_sel  = 2'd0;
    repeat (2) begin
      tick();
      chk("man_ch", 32'(out_ch), 32'd0);
    end
    auto_en = 1'b1;
    tick();
    chk("resume_ch",   32'(out_ch),   32'd2);
    chk("resume_data", 32'(out_data), 32'h0C);
    tick();
    chk("resume_wrap", 32'(out_ch),   32'd0);

    // Out-of-range select.
    auto_en = 1'b0;
    in_sel  = 2'd3;
    tick();
    chk("oor_data", 32'(out_data), 32'h00);
    chk("oor_ch",   32'(out_ch),   32'd3);
`ifdef MUX_INVERT_EN
    inv = 1'b1;
    tick();
    chk("oor_inv_data", 32'(out_data), 32'hFF);
    // Inversion on a live channel.
    in_sel = 2'd0;
    set_data(8'h3C, 8'h00, 8'h00);
    tick();
    chk("inv1_data", 32'(out_data), 32'hC3);
    inv = 1'b0;
    tick();
    chk("inv0_data", 32'(out_data), 32'h3C);
`endif

    // Async reset mid-stall: pointer now 1, stall an auto beat from ch 1.
    set_data(8'h0A, 8'h0B, 8'h0C);
    in_valid  = 1'b0;
    tick();
    auto_en   = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_ch",    32'(out_ch),    32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data",  32'(out_data),  32'h00);
    chk("arst_ready", 32'(in_ready),  32'd1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    chk("post_rst_ch",   32'(out_ch),   32'd0);
    chk("post_rst_data", 32'(out_data), 32'h0A);
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
